// File: rtl/ov7670_dvp_transmitter.sv
// Purpose: synthetic OV7670-style DVP source (vsync/href/RGB565 bytes, high byte first) with programmable geometry.
// Latency: outputs are registered one cycle behind the internal position counters; enable in IDLE -> vsync/frame_start two edges later.
// Backpressure: none; the receiver must accept one byte per clk while href is high.
//
// Ports:
//   clk, reset          byte clock, synchronous active-high reset
//   enable              frame request, sampled in IDLE and on the last cycle of a frame
//   pattern_sel[1:0]    0 counter, 1 solid, 2 colour bars, 3 checker (latched at frame start)
//   solid_color[15:0]   RGB565 colour for the solid pattern (latched at frame start)
//   vsync, href         frame and line qualifiers
//   p_data[7:0]         pixel byte, zero whenever href is low
//   frame_start         pulse on the first vsync cycle
//   frame_done          pulse on the last cycle of the frame
//   busy                high while a frame is in progress
//   frame_count[15:0]   completed frames, wrapping
module ov7670_dvp_transmitter #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int H_BLANK      = 144,
    parameter int VSYNC_LINES  = 3,
    parameter int V_BACK       = 17,
    parameter int V_FRONT      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  p_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy,
    output logic [15:0] frame_count
);

    localparam int ACT_BYTES = 2 * FRAME_WIDTH;
    localparam int LINE_LEN  = ACT_BYTES + H_BLANK;
    localparam int COL_W     = $clog2(LINE_LEN);
    localparam int BAR_W     = FRAME_WIDTH / 8;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
    localparam logic [COL_W-1:0] COL_ACT  = COL_W'(ACT_BYTES);
    localparam logic [15:0]      BAR_LAST = 16'(BAR_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [COL_W-1:0]  col;
    logic [15:0]       line;
    logic [15:0]       bar_cnt;
    logic [2:0]        bar_idx;
    logic [1:0]        pat_q;
    logic [15:0]       solid_q;

    logic [15:0]       state_lines;
    logic              col_last;
    logic              line_last;
    logic              frame_end;
    logic              start_frame;
    logic              act_byte;
    logic [15:0]       x;
    logic [15:0]       pix;
    logic [15:0]       bar_color;

    // Number of lines spent in the current state and the state that follows it.
    always_comb begin
        state_lines = 16'd1;
        state_nxt   = state;
        case (state)
            ST_VSYNC: begin
                state_lines = 16'(VSYNC_LINES);
                state_nxt   = (V_BACK != 0) ? ST_VBACK : ST_ACTIVE;
            end
            ST_VBACK: begin
                state_lines = 16'(V_BACK);
                state_nxt   = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                state_lines = 16'(FRAME_HEIGHT);
                if (V_FRONT != 0)
                    state_nxt = ST_VFRONT;
                else
                    state_nxt = enable ? ST_VSYNC : ST_IDLE;
            end
            ST_VFRONT: begin
                state_lines = 16'(V_FRONT);
                state_nxt   = enable ? ST_VSYNC : ST_IDLE;
            end
            default: begin
                state_lines = 16'd1;
                state_nxt   = ST_IDLE;
            end
        endcase
    end

    assign col_last  = (col == COL_LAST);
    assign line_last = (line == state_lines - 16'd1);
    // The final line of the frame lives in VFRONT, or in ACTIVE when there is no front porch.
    assign frame_end = col_last && line_last &&
                       ((state == ST_VFRONT) || ((state == ST_ACTIVE) && (V_FRONT == 0)));
    assign start_frame = enable && ((state == ST_IDLE) || frame_end);
    assign act_byte    = (state == ST_ACTIVE) && (col < COL_ACT);

    always_comb begin
        x = 16'(col >> 1);
        case (bar_idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
        case (pat_q)
            2'd0:    pix = x + {line[7:0], 8'h00} + frame_count;
            2'd1:    pix = solid_q;
            2'd2:    pix = bar_color;
            default: pix = (x[4] ^ line[4]) ? 16'hFFFF : 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            col         <= '0;
            line        <= '0;
            bar_cnt     <= '0;
            bar_idx     <= '0;
            pat_q       <= '0;
            solid_q     <= '0;
            vsync       <= 1'b0;
            href        <= 1'b0;
            p_data      <= 8'h00;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            // Position counters
            if (state == ST_IDLE) begin
                col  <= '0;
                line <= '0;
                if (enable)
                    state <= ST_VSYNC;
            end else if (col_last) begin
                col <= '0;
                if (line_last) begin
                    line  <= '0;
                    state <= state_nxt;
                end else begin
                    line <= line + 16'd1;
                end
            end else begin
                col <= col + COL_W'(1);
            end

            if (start_frame) begin
                pat_q   <= pattern_sel;
                solid_q <= solid_color;
            end

            // Bar position advances after the low byte of each pixel, so the
            // bar index is already current when the next pixel's high byte goes out.
            if (col_last) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (act_byte && col[0]) begin
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + 16'd1;
                end
            end

            // Registered outputs decoded from the current position
            vsync       <= (state == ST_VSYNC);
            href        <= act_byte;
            p_data      <= act_byte ? (col[0] ? pix[7:0] : pix[15:8]) : 8'h00;
            frame_start <= (state == ST_VSYNC) && (col == '0) && (line == 16'd0);
            frame_done  <= frame_end;
            busy        <= (state != ST_IDLE);
            if (frame_end)
                frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_ov7670_dvp_transmitter.sv
// Purpose: directed self-checking bench for ov7670_dvp_transmitter on a small geometry.
// Latency: compares every output cycle of captured frames against an index-based model.
// Backpressure: not applicable; the DUT free-runs.
module tb_ov7670_dvp_transmitter;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int HB = 3;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int L  = 2 * W + HB;         // 19
    localparam int T  = L * (VS + VB + H + VF); // 95

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_color;
    logic        vsync;
    logic        href;
    logic [7:0]  p_data;
    logic        frame_start;
    logic        frame_done;
    logic        busy;
    logic [15:0] frame_count;

    int n_pass  = 0;
    int n_total = 0;

    // Captured cycles: {vsync, href, p_data, frame_start, frame_done, busy}
    logic [12:0] cap    [0:T];
    logic [15:0] cap_fc [0:T];

    always #5 clk = ~clk;

    ov7670_dvp_transmitter #(
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H),
        .H_BLANK     (HB),
        .VSYNC_LINES (VS),
        .V_BACK      (VB),
        .V_FRONT     (VF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pattern_sel(pattern_sel),
        .solid_color(solid_color),
        .vsync      (vsync),
        .href       (href),
        .p_data     (p_data),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .busy       (busy),
        .frame_count(frame_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_start(input logic [1:0] pat, input logic [15:0] solid);
        reset = 1'b1;
        enable = 1'b0;
        step();
        step();
        pattern_sel = pat;
        solid_color = solid;
        enable = 1'b1;
        reset = 1'b0;
    endtask

    // Waits (bounded) for frame_start, then records T+1 cycles starting there.
    // At index drop_idx the enable is dropped and the pattern inputs scrambled.
    task automatic capture_frame(output bit found, input int drop_idx);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        if (found) begin
            for (int i = 0; i <= T; i++) begin
                cap[i]    = {vsync, href, p_data, frame_start, frame_done, busy};
                cap_fc[i] = frame_count;
                if (i == drop_idx) begin
                    enable      = 1'b0;
                    pattern_sel = 2'd2;
                    solid_color = 16'h0000;
                end
                if (i < T) step();
            end
        end
    endtask

    function automatic logic [15:0] model_pix(input logic [1:0] pat, input logic [15:0] solid,
                                              input int x, input int y, input logic [15:0] fc);
        logic [15:0] p;
        case (pat)
            2'd0: p = 16'(x + y * 256) + fc;
            2'd1: p = solid;
            2'd2: begin
                case (x / (W / 8))
                    0: p = 16'hFFFF;
                    1: p = 16'hFFE0;
                    2: p = 16'h07FF;
                    3: p = 16'h07E0;
                    4: p = 16'hF81F;
                    5: p = 16'hF800;
                    6: p = 16'h001F;
                    default: p = 16'h0000;
                endcase
            end
            default: p = ((((x >> 4) ^ (y >> 4)) & 1) == 1) ? 16'hFFFF : 16'h0000;
        endcase
        return p;
    endfunction

    function automatic logic [12:0] model_vec(input int idx, input logic [1:0] pat,
                                              input logic [15:0] solid, input logic [15:0] fc,
                                              input bit next_frame);
        int li;
        int c;
        bit vs;
        bit act;
        logic [15:0] p;
        logic [7:0] b;
        if (idx == T)
            return next_frame ? 13'b1_0_00000000_1_0_1 : 13'd0;
        li  = idx / L;
        c   = idx % L;
        vs  = (li < VS);
        act = (li >= VS + VB) && (li < VS + VB + H) && (c < 2 * W);
        p   = model_pix(pat, solid, c / 2, li - VS - VB, fc);
        b   = act ? ((c % 2 == 1) ? p[7:0] : p[15:8]) : 8'h00;
        return {vs, act, b, (idx == 0), (idx == T - 1), 1'b1};
    endfunction

    task automatic test_reset();
        int n;
        reset = 1'b1;
        enable = 1'b1;
        pattern_sel = 2'd1;
        solid_color = 16'hF81F;
        repeat (3) step();
        n_total++;
        if ({vsync, href, p_data, frame_start, frame_done, busy} !== 13'd0)
            $display("FAIL reset_outputs: got %h want 0000", {vsync, href, p_data, frame_start, frame_done, busy});
        else n_pass++;
        n_total++;
        if (frame_count !== 16'd0)
            $display("FAIL reset_frame_count: got %h want 0000", frame_count);
        else n_pass++;
        reset = 1'b0;
        step();
        n_total++;
        if (frame_start !== 1'b0)
            $display("FAIL release_no_start: got %b want 0", frame_start);
        else n_pass++;
        step();
        n_total++;
        if (frame_start !== 1'b1) $display("FAIL start_pulse: got %b want 1", frame_start);
        else n_pass++;
        n_total++;
        if (vsync !== 1'b1) $display("FAIL start_vsync: got %b want 1", vsync);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy);
        else n_pass++;
        n = 0;
        while (vsync === 1'b1 && n < 100) begin
            n++;
            step();
        end
        n_total++;
        if (n != L) $display("FAIL vsync_length: got %0d want %0d", n, L);
        else n_pass++;
    endtask

    task automatic test_solid();
        bit found;
        int bursts;
        int hcycles;
        logic [12:0] e;
        reset_and_start(2'd1, 16'hF81F);
        capture_frame(found, -1);
        n_total++;
        if (!found) $display("FAIL solid_frame_start: got none want pulse");
        else n_pass++;
        if (found) begin
            for (int i = 0; i <= T; i++) begin
                e = model_vec(i, 2'd1, 16'hF81F, 16'd0, 1'b1);
                n_total++;
                if (cap[i] !== e) $display("FAIL solid idx %0d: got %h want %h", i, cap[i], e);
                else n_pass++;
            end
            bursts = 0;
            hcycles = 0;
            for (int i = 0; i < T; i++) begin
                if (cap[i][11]) begin
                    hcycles++;
                    if (i == 0 || !cap[i-1][11]) bursts++;
                end
            end
            n_total++;
            if (bursts != H) $display("FAIL solid_bursts: got %0d want %0d", bursts, H);
            else n_pass++;
            n_total++;
            if (hcycles != 2 * W * H) $display("FAIL solid_href_bytes: got %0d want %0d", hcycles, 2 * W * H);
            else n_pass++;
        end
    endtask

    task automatic test_bars();
        bit found;
        logic [12:0] e;
        reset_and_start(2'd2, 16'h0000);
        capture_frame(found, -1);
        n_total++;
        if (!found) $display("FAIL bars_frame_start: got none want pulse");
        else n_pass++;
        if (found) begin
            for (int i = 0; i <= T; i++) begin
                e = model_vec(i, 2'd2, 16'h0000, 16'd0, 1'b1);
                n_total++;
                if (cap[i] !== e) $display("FAIL bars idx %0d: got %h want %h", i, cap[i], e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_counter();
        bit found;
        logic [12:0] e;
        logic [15:0] px;
        reset_and_start(2'd0, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            capture_frame(found, -1);
            n_total++;
            if (!found) $display("FAIL counter_frame_start %0d: got none want pulse", k);
            else n_pass++;
            if (found) begin
                for (int i = 0; i <= T; i++) begin
                    e = model_vec(i, 2'd0, 16'h0000, 16'(k), 1'b1);
                    n_total++;
                    if (cap[i] !== e) $display("FAIL counter f%0d idx %0d: got %h want %h", k, i, cap[i], e);
                    else n_pass++;
                end
                px = {cap[38][10:3], cap[39][10:3]};
                n_total++;
                if (px !== 16'(k)) $display("FAIL counter_first_pix f%0d: got %h want %h", k, px, 16'(k));
                else n_pass++;
                n_total++;
                if (cap_fc[T-1] !== 16'(k + 1))
                    $display("FAIL counter_fc_at_done f%0d: got %h want %h", k, cap_fc[T-1], 16'(k + 1));
                else n_pass++;
                if (k == 0) begin
                    px = {cap[63][10:3], cap[64][10:3]};
                    n_total++;
                    if (px !== 16'h0103) $display("FAIL counter_line1_x3: got %h want 0103", px);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (frame_count !== 16'd3) $display("FAIL counter_frame_count: got %h want 0003", frame_count);
        else n_pass++;
    endtask

    task automatic test_enable_drop();
        bit found;
        int vs_hi;
        int busy_hi;
        logic [12:0] e;
        reset_and_start(2'd1, 16'h1234);
        capture_frame(found, 50);
        n_total++;
        if (!found) $display("FAIL drop_frame_start: got none want pulse");
        else n_pass++;
        if (found) begin
            for (int i = 0; i <= T; i++) begin
                e = model_vec(i, 2'd1, 16'h1234, 16'd0, 1'b0);
                n_total++;
                if (cap[i] !== e) $display("FAIL drop idx %0d: got %h want %h", i, cap[i], e);
                else n_pass++;
            end
            vs_hi = 0;
            busy_hi = 0;
            for (int i = 0; i < 200; i++) begin
                step();
                if (vsync !== 1'b0) vs_hi++;
                if (busy !== 1'b0) busy_hi++;
            end
            n_total++;
            if (vs_hi != 0) $display("FAIL drop_no_vsync: got %0d want 0", vs_hi);
            else n_pass++;
            n_total++;
            if (busy_hi != 0) $display("FAIL drop_idle_busy: got %0d want 0", busy_hi);
            else n_pass++;
            n_total++;
            if (frame_count !== 16'd1) $display("FAIL drop_frame_count: got %h want 0001", frame_count);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int fd_seen;
        logic [12:0] e;
        reset_and_start(2'd0, 16'h0000);
        capture_frame(found, -1);
        n_total++;
        if (!found) $display("FAIL rmid_frame0: got none want pulse");
        else n_pass++;
        // Now on frame 1 index 0; move to ACTIVE line 1, column 2.
        repeat (59) step();
        n_total++;
        if ({href, frame_count} !== {1'b1, 16'd1})
            $display("FAIL rmid_before: got %h want %h", {href, frame_count}, {1'b1, 16'd1});
        else n_pass++;
        reset = 1'b1;
        pattern_sel = 2'd3;
        step();
        n_total++;
        if ({vsync, href, p_data, frame_start, frame_done, busy, frame_count} !== 29'd0)
            $display("FAIL rmid_outputs: got %h want 0", {vsync, href, p_data, frame_start, frame_done, busy, frame_count});
        else n_pass++;
        fd_seen = 0;
        repeat (3) begin
            step();
            if (frame_done !== 1'b0) fd_seen++;
        end
        n_total++;
        if (fd_seen != 0) $display("FAIL rmid_no_done: got %0d want 0", fd_seen);
        else n_pass++;
        reset = 1'b0;
        step();
        n_total++;
        if (frame_start !== 1'b0) $display("FAIL rmid_release: got %b want 0", frame_start);
        else n_pass++;
        step();
        n_total++;
        if ({frame_start, frame_count} !== {1'b1, 16'd0})
            $display("FAIL rmid_restart: got %h want %h", {frame_start, frame_count}, {1'b1, 16'd0});
        else n_pass++;
        capture_frame(found, -1);
        n_total++;
        if (!found) $display("FAIL rmid_frame_start: got none want pulse");
        else n_pass++;
        if (found) begin
            for (int i = 0; i <= T; i++) begin
                e = model_vec(i, 2'd3, 16'h0000, 16'd0, 1'b1);
                n_total++;
                if (cap[i] !== e) $display("FAIL rmid idx %0d: got %h want %h", i, cap[i], e);
                else n_pass++;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        pattern_sel = 2'd0;
        solid_color = 16'h0000;
        test_reset();
        test_solid();
        test_bars();
        test_counter();
        test_enable_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
